// File: rtl/mips_multicycle_ctrl.sv
// rtl/mips_multicycle_ctrl.sv - multi-cycle MIPS control FSM with memory stall/timeout trap
// Optional MCTRL_PERF_EN adds retired_cnt (retired-instruction counter).
module mips_multicycle_ctrl #(
    parameter int MEM_TIMEOUT = 16,
    parameter int TW          = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [5:0]  opcode,
    input  logic        zero,
    input  logic        mem_ready,
    output logic        pc_write,
    output logic        pc_write_cond,
    output logic        branch_ne,
    output logic        i_or_d,
    output logic        mem_read,
    output logic        mem_write,
    output logic        ir_write,
    output logic        reg_dst,
    output logic        reg_write,
    output logic        mem_to_reg,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  alu_op,
    output logic [1:0]  pc_source,
    output logic        illegal_op,
    output logic        bus_err,
    output logic [3:0]  state
`ifdef MCTRL_PERF_EN
    ,
    output logic [31:0] retired_cnt
`endif
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_EXEC_R   = 4'd6,
        S_R_WB     = 4'd7,
        S_BRANCH   = 4'd8,
        S_JUMP     = 4'd9,
        S_EXEC_I   = 4'd10,
        S_I_WB     = 4'd11,
        S_TRAP     = 4'd12
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_SLTI = 6'b001010;

    state_t          state_q, state_d;
    logic [TW-1:0]   wait_q, wait_d;
    logic            cause_bus_q, cause_bus_d;
    logic            mem_state;
    logic            timeout;
    logic            unused_zero;

    // zero only feeds the datapath branch gate; it is never sampled here
    assign unused_zero = zero;

    assign mem_state = (state_q == S_FETCH) || (state_q == S_MEM_RD) || (state_q == S_MEM_WR);
    assign timeout   = mem_state && !mem_ready && (wait_q == TW'(MEM_TIMEOUT - 1));
    assign state     = state_q;

    always_comb begin
        wait_d = '0;
        if (mem_state && !mem_ready && !timeout) begin
            wait_d = wait_q + 1'b1;
        end
    end

    always_comb begin
        state_d       = state_q;
        cause_bus_d   = cause_bus_q;
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        branch_ne     = 1'b0;
        i_or_d        = 1'b0;
        mem_read      = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_dst       = 1'b0;
        reg_write     = 1'b0;
        mem_to_reg    = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        pc_source     = 2'b00;
        illegal_op    = 1'b0;
        bus_err       = 1'b0;
        if (!reset) begin
            case (state_q)
                S_FETCH: begin
                    mem_read  = 1'b1;
                    alu_src_b = 2'b01;
                    if (mem_ready) begin
                        ir_write = 1'b1;
                        pc_write = 1'b1;
                        state_d  = S_DECODE;
                    end else if (timeout) begin
                        cause_bus_d = 1'b1;
                        state_d     = S_TRAP;
                    end
                end
                S_DECODE: begin
                    alu_src_b = 2'b11;
                    case (opcode)
                        OP_R:                             state_d = S_EXEC_R;
                        OP_LW, OP_SW:                     state_d = S_MEM_ADDR;
                        OP_BEQ, OP_BNE:                   state_d = S_BRANCH;
                        OP_J:                             state_d = S_JUMP;
                        OP_ADDI, OP_ANDI, OP_ORI, OP_SLTI: state_d = S_EXEC_I;
                        default: begin
                            cause_bus_d = 1'b0;
                            state_d     = S_TRAP;
                        end
                    endcase
                end
                S_MEM_ADDR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                    state_d   = (opcode == OP_SW) ? S_MEM_WR : S_MEM_RD;
                end
                S_MEM_RD: begin
                    mem_read = 1'b1;
                    i_or_d   = 1'b1;
                    if (mem_ready) begin
                        state_d = S_MEM_WB;
                    end else if (timeout) begin
                        cause_bus_d = 1'b1;
                        state_d     = S_TRAP;
                    end
                end
                S_MEM_WB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                    state_d    = S_FETCH;
                end
                S_MEM_WR: begin
                    mem_write = 1'b1;
                    i_or_d    = 1'b1;
                    if (mem_ready) begin
                        state_d = S_FETCH;
                    end else if (timeout) begin
                        cause_bus_d = 1'b1;
                        state_d     = S_TRAP;
                    end
                end
                S_EXEC_R: begin
                    alu_src_a = 1'b1;
                    alu_op    = 2'b10;
                    state_d   = S_R_WB;
                end
                S_R_WB: begin
                    reg_write = 1'b1;
                    reg_dst   = 1'b1;
                    state_d   = S_FETCH;
                end
                S_EXEC_I: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                    alu_op    = 2'b11;
                    state_d   = S_I_WB;
                end
                S_I_WB: begin
                    reg_write = 1'b1;
                    state_d   = S_FETCH;
                end
                S_BRANCH: begin
                    alu_src_a     = 1'b1;
                    alu_op        = 2'b01;
                    pc_write_cond = 1'b1;
                    pc_source     = 2'b01;
                    branch_ne     = (opcode == OP_BNE);
                    state_d       = S_FETCH;
                end
                S_JUMP: begin
                    pc_write  = 1'b1;
                    pc_source = 2'b10;
                    state_d   = S_FETCH;
                end
                S_TRAP: begin
                    pc_write   = 1'b1;
                    pc_source  = 2'b11;
                    illegal_op = !cause_bus_q;
                    bus_err    = cause_bus_q;
                    state_d    = S_FETCH;
                end
                default: state_d = S_FETCH;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_FETCH;
            wait_q      <= '0;
            cause_bus_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            cause_bus_q <= cause_bus_d;
        end
    end

`ifdef MCTRL_PERF_EN
    logic        retire;
    logic [31:0] retired_q;

    // TRAP exits and stray encodings return to FETCH without retiring
    assign retire = (state_d == S_FETCH) &&
                    ((state_q == S_MEM_WB) || (state_q == S_MEM_WR) || (state_q == S_R_WB) ||
                     (state_q == S_I_WB) || (state_q == S_BRANCH) || (state_q == S_JUMP));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            retired_q <= '0;
        end else if (retire) begin
            retired_q <= retired_q + 32'd1;
        end
    end

    assign retired_cnt = retired_q;
`endif

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// tb/tb_mips_multicycle_ctrl.sv - scoreboard bench for mips_multicycle_ctrl
module tb_mips_multicycle_ctrl;

    localparam int MT = 16;

    typedef struct packed {
        logic       pcw, pcwc, bne, iord, mrd, mwr, irw, rdst, rw, m2r, asa;
        logic [1:0] asb, aop, psrc;
        logic       ill, berr;
        logic [3:0] st;
    } out_t;

    logic        clk = 1'b0;
    logic        reset, zero, mem_ready;
    logic [5:0]  opcode;
    logic        pc_write, pc_write_cond, branch_ne, i_or_d, mem_read, mem_write, ir_write;
    logic        reg_dst, reg_write, mem_to_reg, alu_src_a, illegal_op, bus_err;
    logic [1:0]  alu_src_b, alu_op, pc_source;
    logic [3:0]  state;
`ifdef MCTRL_PERF_EN
    logic [31:0] retired_cnt;
`endif

    mips_multicycle_ctrl #(.MEM_TIMEOUT(MT), .TW(8)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .branch_ne(branch_ne),
        .i_or_d(i_or_d), .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
        .reg_dst(reg_dst), .reg_write(reg_write), .mem_to_reg(mem_to_reg),
        .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_source(pc_source),
        .illegal_op(illegal_op), .bus_err(bus_err), .state(state)
`ifdef MCTRL_PERF_EN
        , .retired_cnt(retired_cnt)
`endif
    );

    always #5 clk = ~clk;

    out_t act;
    assign act = {pc_write, pc_write_cond, branch_ne, i_or_d, mem_read, mem_write, ir_write,
                  reg_dst, reg_write, mem_to_reg, alu_src_a, alu_src_b, alu_op, pc_source,
                  illegal_op, bus_err, state};

    out_t expq[$];
    int   n_pass = 0;
    int   n_chk  = 0;
    int   model_retired = 0;

    function automatic void chk(string nm, logic [31:0] a, logic [31:0] e);
        n_chk++;
        if (a === e) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, a, e);
    endfunction

    // Expected outputs for one cycle, written straight from the state table
    function automatic out_t model(int st, logic [5:0] op, bit rdy, bit bus);
        out_t e = '0;
        e.st = 4'(st);
        case (st)
            0:  begin e.mrd = 1; e.asb = 2'b01; if (rdy) begin e.irw = 1; e.pcw = 1; end end
            1:  e.asb = 2'b11;
            2:  begin e.asa = 1; e.asb = 2'b10; end
            3:  begin e.mrd = 1; e.iord = 1; end
            4:  begin e.rw = 1; e.m2r = 1; end
            5:  begin e.mwr = 1; e.iord = 1; end
            6:  begin e.asa = 1; e.aop = 2'b10; end
            7:  begin e.rw = 1; e.rdst = 1; end
            8:  begin e.asa = 1; e.aop = 2'b01; e.pcwc = 1; e.psrc = 2'b01; e.bne = (op == 6'b000101); end
            9:  begin e.pcw = 1; e.psrc = 2'b10; end
            10: begin e.asa = 1; e.asb = 2'b10; e.aop = 2'b11; end
            11: e.rw = 1;
            12: begin e.pcw = 1; e.psrc = 2'b11; e.ill = !bus; e.berr = bus; end
            default: e = '0;
        endcase
        return e;
    endfunction

    always @(negedge clk) begin : monitor
        out_t e;
        if (expq.size() != 0) begin
            e = expq.pop_front();
            chk($sformatf("cycle_st%0d", e.st), 32'(act), 32'(e));
        end
    end

    task automatic step(int st, logic [5:0] op, bit rdy, bit bus);
        opcode    = op;
        mem_ready = rdy;
        zero      = 1'($urandom);
        expq.push_back(model(st, op, rdy, bus));
        @(posedge clk);
        #1;
    endtask

    task automatic step_rst();
        mem_ready = 1'($urandom);
        opcode    = 6'($urandom);
        expq.push_back('0);
        @(posedge clk);
        #1;
    endtask

    // nwait idle cycles, then ready; returns 1 when the access times out instead
    task automatic mem_phase(int st, logic [5:0] op, int nwait, output bit to);
        to = 0;
        for (int i = 0; ; i++) begin
            if (i == nwait) begin
                step(st, op, 1'b1, 1'b0);
                return;
            end
            step(st, op, 1'b0, 1'b0);
            if (i == MT - 1) begin
                to = 1;
                return;
            end
        end
    endtask

    task automatic run_instr(logic [5:0] op, int fw, int mw);
        bit to;
        mem_phase(0, 6'($urandom), fw, to);
        if (to) begin
            step(12, 6'($urandom), 1'($urandom), 1'b1);
            return;
        end
        step(1, op, 1'($urandom), 1'b0);
        case (op)
            6'b000000: begin step(6, op, 1'($urandom), 0); step(7, op, 1'($urandom), 0); model_retired++; end
            6'b100011: begin
                step(2, op, 1'($urandom), 0);
                mem_phase(3, op, mw, to);
                if (to) step(12, op, 1'($urandom), 1'b1);
                else begin step(4, op, 1'($urandom), 0); model_retired++; end
            end
            6'b101011: begin
                step(2, op, 1'($urandom), 0);
                mem_phase(5, op, mw, to);
                if (to) step(12, op, 1'($urandom), 1'b1);
                else model_retired++;
            end
            6'b000100, 6'b000101: begin step(8, op, 1'($urandom), 0); model_retired++; end
            6'b000010: begin step(9, op, 1'($urandom), 0); model_retired++; end
            6'b001000, 6'b001100, 6'b001101, 6'b001010: begin
                step(10, op, 1'($urandom), 0); step(11, op, 1'($urandom), 0); model_retired++;
            end
            default: step(12, op, 1'($urandom), 1'b0);
        endcase
    endtask

    function automatic int rand_wait();
        int r = $urandom_range(0, 9);
        if (r <= 5) return 0;
        if (r <= 7) return $urandom_range(1, 4);
        if (r == 8) return MT - 1;
        return MT;
    endfunction

    function automatic logic [5:0] rand_op();
        logic [5:0] ops [10] = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000101,
                                 6'b000010, 6'b001000, 6'b001100, 6'b001101, 6'b001010};
        if ($urandom_range(0, 7) == 0) return 6'($urandom);
        return ops[$urandom_range(0, 9)];
    endfunction

    initial begin
        reset = 1'b1; mem_ready = 1'b0; opcode = '0; zero = 1'b0;
        @(posedge clk);
        #1;
        step_rst();
        step_rst();
        reset = 1'b0;

        run_instr(6'b000000, 0, 0);
        run_instr(6'b100011, 0, 3);
        run_instr(6'b000101, 0, 0);
        run_instr(6'b000100, 0, 0);
        run_instr(6'b111111, 0, 0);
        run_instr(6'b000000, MT, 0);
        run_instr(6'b000000, MT - 1, 0);
        run_instr(6'b101011, 0, MT);
        run_instr(6'b100011, 1, MT - 1);
        run_instr(6'b001010, 0, 0);
        run_instr(6'b000010, 2, 0);
        for (int i = 0; i < 150; i++) run_instr(rand_op(), rand_wait(), rand_wait());
`ifdef MCTRL_PERF_EN
        chk("retired_cnt_random", retired_cnt, 32'(model_retired));
`endif

        // asynchronous reset in the middle of a store
        step(0, 6'($urandom), 1'b1, 1'b0);
        step(1, 6'b101011, 1'b0, 1'b0);
        step(2, 6'b101011, 1'b0, 1'b0);
        opcode = 6'b101011; mem_ready = 1'b0;
        #2;
        chk("mem_wr_before_reset", 32'(act), 32'(model(5, 6'b101011, 1'b0, 1'b0)));
        reset = 1'b1;
        #1;
        chk("async_reset_outputs", 32'(act), 32'd0);
        model_retired = 0;
        step_rst();
        step_rst();
        reset = 1'b0;

        run_instr(6'b000000, 0, 0);
        run_instr(6'b000010, 0, 0);
        run_instr(6'b111110, 0, 0);
        run_instr(6'b000100, 0, 0);
`ifdef MCTRL_PERF_EN
        chk("retired_cnt_after_reset", retired_cnt, 32'(model_retired));
`endif
        chk("queue_drained", 32'(expq.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
